// File: rtl/mul_reg_datain_pkg.sv
// Shared constants for the 8-entry data register file: FSM encodings,
// register addresses and register count, also used by the read multiplexer.
package mul_reg_datain_pkg;

   localparam int NUM_REGS = 8;
   localparam int ADDR_W   = 3;

   localparam logic [ADDR_W-1:0] ADDR_000 = 3'b000;
   localparam logic [ADDR_W-1:0] ADDR_001 = 3'b001;
   localparam logic [ADDR_W-1:0] ADDR_010 = 3'b010;
   localparam logic [ADDR_W-1:0] ADDR_011 = 3'b011;
   localparam logic [ADDR_W-1:0] ADDR_100 = 3'b100;
   localparam logic [ADDR_W-1:0] ADDR_101 = 3'b101;
   localparam logic [ADDR_W-1:0] ADDR_110 = 3'b110;
   localparam logic [ADDR_W-1:0] ADDR_111 = 3'b111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/mul_reg_datain_reg_byte_cell.sv
// One WIDTH-bit storage register with write enable; loads RESET_VALUE
// asynchronously while rst_n is low.
module reg_byte_cell #(
   parameter int                WIDTH       = 8,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_reg <= RESET_VALUE;
      end else if (we) begin
         q_reg <= d;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/mul_reg_datain.sv
// Write side of the 8-entry data register file: handshaked single writes,
// an 8-cycle bulk-clear sweep, and all register contents presented in parallel.
module mul_reg_datain
   import mul_reg_datain_pkg::*;
#(
   parameter int                WIDTH          = 8,
   parameter logic [WIDTH-1:0]  RESET_VALUE    = '0,
   parameter logic [WIDTH-1:0]  CLEAR_VALUE    = '0,
   parameter bit                REG0_HARDWIRED = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] Datain_address,
   input  logic              Enable_in,
   input  logic [WIDTH-1:0]  Datain,
   input  logic              Clear_req,
   output logic              Busy,
   output logic              Wr_ack,
   output logic              Wr_reject,
   output logic              Clear_done,
   output logic [WIDTH-1:0]  out_000,
   output logic [WIDTH-1:0]  out_001,
   output logic [WIDTH-1:0]  out_010,
   output logic [WIDTH-1:0]  out_011,
   output logic [WIDTH-1:0]  out_100,
   output logic [WIDTH-1:0]  out_101,
   output logic [WIDTH-1:0]  out_110,
   output logic [WIDTH-1:0]  out_111
);

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] cnt_reg, cnt_next;
   logic              ack_reg, ack_next;
   logic              reject_reg, reject_next;
   logic              done_reg, done_next;

   logic              wr_fire;
   logic [ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]  wr_data;
   logic [WIDTH-1:0]  reg_q [NUM_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         ack_reg    <= 1'b0;
         reject_reg <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         ack_reg    <= ack_next;
         reject_reg <= reject_next;
         done_reg   <= done_next;
      end
   end

   // Clear wins over a simultaneous write; any write seen during the sweep is rejected.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      ack_next    = 1'b0;
      reject_next = 1'b0;
      done_next   = 1'b0;
      wr_fire     = 1'b0;
      wr_addr     = Datain_address;
      wr_data     = Datain;
      unique case (state_reg)
         ST_IDLE: begin
            if (Clear_req) begin
               state_next  = ST_CLEAR;
               cnt_next    = '0;
               reject_next = Enable_in;
            end else if (Enable_in) begin
               if (REG0_HARDWIRED && (Datain_address == ADDR_000)) begin
                  reject_next = 1'b1;
               end else begin
                  wr_fire  = 1'b1;
                  ack_next = 1'b1;
               end
            end
         end
         ST_CLEAR: begin
            wr_fire     = 1'b1;
            wr_addr     = cnt_reg;
            wr_data     = CLEAR_VALUE;
            reject_next = Enable_in;
            cnt_next    = ADDR_W'(cnt_reg + 1'b1);
            if (cnt_reg == ADDR_111) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
               done_next  = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         if (gi == 0 && REG0_HARDWIRED) begin : g_tied
            // Hardwired slot: sweep writes to it are harmless no-ops.
            assign reg_q[gi] = RESET_VALUE;
         end else begin : g_cell
            reg_byte_cell #(
               .WIDTH       (WIDTH),
               .RESET_VALUE (RESET_VALUE)
            ) u_cell (
               .clk   (clk),
               .rst_n (rst_n),
               .we    (wr_fire && (wr_addr == ADDR_W'(gi))),
               .d     (wr_data),
               .q     (reg_q[gi])
            );
         end
      end
   endgenerate

   assign Busy       = (state_reg == ST_CLEAR);
   assign Wr_ack     = ack_reg;
   assign Wr_reject  = reject_reg;
   assign Clear_done = done_reg;

   assign out_000 = reg_q[ADDR_000];
   assign out_001 = reg_q[ADDR_001];
   assign out_010 = reg_q[ADDR_010];
   assign out_011 = reg_q[ADDR_011];
   assign out_100 = reg_q[ADDR_100];
   assign out_101 = reg_q[ADDR_101];
   assign out_110 = reg_q[ADDR_110];
   assign out_111 = reg_q[ADDR_111];

endmodule

// File: tb/tb_mul_reg_datain.sv
// Bench for mul_reg_datain: two instances (plain and register-0 hardwired)
// driven identically and checked every cycle against a behavioural model.
module tb_mul_reg_datain;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] addr = '0;
   logic       en = 1'b0;
   logic [7:0] din = '0;
   logic       clr = 1'b0;

   logic       busy [2];
   logic       ack  [2];
   logic       rej  [2];
   logic       done [2];
   logic [7:0] o0 [8];
   logic [7:0] o1 [8];

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   mul_reg_datain #(
      .WIDTH(8), .RESET_VALUE(8'h00), .CLEAR_VALUE(8'hFF), .REG0_HARDWIRED(1'b0)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .Datain_address(addr), .Enable_in(en),
      .Datain(din), .Clear_req(clr), .Busy(busy[0]), .Wr_ack(ack[0]),
      .Wr_reject(rej[0]), .Clear_done(done[0]),
      .out_000(o0[0]), .out_001(o0[1]), .out_010(o0[2]), .out_011(o0[3]),
      .out_100(o0[4]), .out_101(o0[5]), .out_110(o0[6]), .out_111(o0[7])
   );

   mul_reg_datain #(
      .WIDTH(8), .RESET_VALUE(8'h5A), .CLEAR_VALUE(8'hC3), .REG0_HARDWIRED(1'b1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .Datain_address(addr), .Enable_in(en),
      .Datain(din), .Clear_req(clr), .Busy(busy[1]), .Wr_ack(ack[1]),
      .Wr_reject(rej[1]), .Clear_done(done[1]),
      .out_000(o1[0]), .out_001(o1[1]), .out_010(o1[2]), .out_011(o1[3]),
      .out_100(o1[4]), .out_101(o1[5]), .out_110(o1[6]), .out_111(o1[7])
   );

   // Behavioural model: m_sweep is the next register the sweep will clear, -1 when idle.
   logic [7:0] rv [2] = '{8'h00, 8'h5A};
   logic [7:0] cv [2] = '{8'hFF, 8'hC3};
   logic [7:0] m_regs [2][8];
   logic       m_ack [2], m_rej [2], m_done [2];
   int         m_sweep = -1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sweep = -1;
         for (int h = 0; h < 2; h++) begin
            m_ack[h] = 1'b0; m_rej[h] = 1'b0; m_done[h] = 1'b0;
            for (int r = 0; r < 8; r++) m_regs[h][r] = rv[h];
         end
      end else begin
         for (int h = 0; h < 2; h++) begin
            m_ack[h] = 1'b0; m_rej[h] = 1'b0; m_done[h] = 1'b0;
            if (m_sweep < 0) begin
               if (clr) begin
                  m_rej[h] = en;
               end else if (en) begin
                  if (h == 1 && addr == 3'd0) m_rej[h] = 1'b1;
                  else begin
                     m_regs[h][addr] = din;
                     m_ack[h] = 1'b1;
                  end
               end
            end else begin
               m_rej[h] = en;
               if (!(h == 1 && m_sweep == 0)) m_regs[h][m_sweep] = cv[h];
               if (m_sweep == 7) m_done[h] = 1'b1;
            end
         end
         if (m_sweep < 0) begin
            if (clr) m_sweep = 0;
         end else if (m_sweep == 7) m_sweep = -1;
         else m_sweep = m_sweep + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int h = 0; h < 2; h++) begin
            chk($sformatf("busy%0d", h), 32'(busy[h]), 32'(m_sweep >= 0));
            chk($sformatf("ack%0d", h), 32'(ack[h]), 32'(m_ack[h]));
            chk($sformatf("reject%0d", h), 32'(rej[h]), 32'(m_rej[h]));
            chk($sformatf("done%0d", h), 32'(done[h]), 32'(m_done[h]));
            for (int r = 0; r < 8; r++)
               chk($sformatf("out%0d_reg%0d", h, r), 32'(h == 0 ? o0[r] : o1[r]),
                   32'(m_regs[h][r]));
         end
      end
   end

   // Inputs change 2 time units after the rising edge; the next edge samples them.
   task automatic apply(input logic e, input logic [2:0] a, input logic [7:0] d,
                        input logic c);
      en = e; addr = a; din = d; clr = c;
      @(posedge clk);
      #2;
   endtask

   initial begin
      int bc, dc, done_at;
      repeat (2) @(posedge clk);
      #2;
      chk_en = 1'b1;
      apply(0, 0, 0, 0);
      rst_n = 1'b1;
      apply(0, 0, 0, 0);
      chk("reset_out000", 32'(o0[0]), 32'h00);
      chk("reset_out111", 32'(o0[7]), 32'h00);
      chk("reset_busy", 32'(busy[0]), 32'h0);
      chk("reset_ack", 32'(ack[0]), 32'h0);
      chk("reset_hw_out000", 32'(o1[0]), 32'h5A);

      apply(1, 3'b101, 8'hA5, 0);
      chk("wr1_out101", 32'(o0[5]), 32'hA5);
      chk("wr1_ack", 32'(ack[0]), 32'h1);
      chk("wr1_out100", 32'(o0[4]), 32'h00);
      apply(1, 3'b101, 8'h3C, 0);
      chk("wr2_out101", 32'(o0[5]), 32'h3C);
      chk("wr2_ack_still", 32'(ack[0]), 32'h1);
      apply(0, 0, 0, 0);
      chk("wr_ack_drop", 32'(ack[0]), 32'h0);

      for (int i = 0; i < 8; i++) apply(1, 3'(i), 8'((i + 1) * 17), 0);
      apply(0, 0, 0, 1);
      bc = 0; dc = 0; done_at = -1;
      for (int k = 0; k < 12; k++) begin
         if (busy[0]) bc++;
         if (done[0]) begin dc++; done_at = k; end
         if (k >= 1 && k <= 8) chk("sweep_cleared", 32'(o0[k - 1]), 32'hFF);
         if (k <= 7) chk("sweep_pending", 32'(o0[k]), 32'((k + 1) * 17));
         apply(0, 0, 0, 0);
      end
      chk("sweep_busy_cycles", 32'(bc), 32'd8);
      chk("sweep_done_count", 32'(dc), 32'd1);
      chk("sweep_done_cycle", 32'(done_at), 32'd8);

      apply(1, 3'b010, 8'h55, 1);
      chk("clr_prio_reject", 32'(rej[0]), 32'h1);
      chk("clr_prio_busy", 32'(busy[0]), 32'h1);
      apply(0, 0, 0, 0);
      apply(0, 0, 0, 0);
      apply(1, 3'b010, 8'h99, 0);
      chk("sweep_wr_reject", 32'(rej[0]), 32'h1);
      chk("sweep_wr_noack", 32'(ack[0]), 32'h0);
      repeat (6) apply(0, 0, 0, 0);
      chk("sweep_out010", 32'(o0[2]), 32'hFF);

      apply(1, 3'b000, 8'h77, 0);
      chk("hw_reject", 32'(rej[1]), 32'h1);
      chk("hw_noack", 32'(ack[1]), 32'h0);
      chk("hw_out000", 32'(o1[0]), 32'h5A);
      chk("plain_out000", 32'(o0[0]), 32'h77);
      apply(0, 0, 0, 0);

      apply(0, 0, 0, 1);
      apply(0, 0, 0, 0);
      apply(0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy[0]), 32'h0);
      chk("midrst_out011", 32'(o0[3]), 32'h00);
      chk("midrst_hw_out101", 32'(o1[5]), 32'h5A);
      apply(0, 0, 0, 0);
      apply(0, 0, 0, 0);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         apply(0, 0, 0, 0);
         chk("postrst_nodone", 32'(done[0]), 32'h0);
         chk("postrst_idle", 32'(busy[0]), 32'h0);
      end

      for (int k = 0; k < 600; k++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         apply(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               8'($urandom_range(0, 255)), 1'($urandom_range(0, 15) == 0));
      end
      rst_n = 1'b1;
      repeat (3) apply(0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
